// File: rtl/alpha_blend_pkg.sv
// Shared types, Q4.12 constants and saturation helper for the alpha blender.
package alpha_blend_pkg;

    localparam int ACC_W = 34;

    typedef enum logic [2:0] {
        BLEND_DISABLED = 3'b000,
        BLEND_ADD      = 3'b001,
        BLEND_SUBTRACT = 3'b010,
        BLEND_BLEND    = 3'b011
    } blend_mode_e;

    localparam logic signed [15:0] Q412_ONE  = 16'sh1000;
    localparam logic signed [15:0] Q412_ZERO = 16'sh0000;

    // Saturate a wide signed intermediate into the displayable range [0.0, 1.0].
    function automatic logic signed [15:0] q412_clamp(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] one_x;
        one_x = {{(ACC_W-16){1'b0}}, Q412_ONE};
        if (v[ACC_W-1])
            return Q412_ZERO;
        else if (v > one_x)
            return Q412_ONE;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/alpha_blend_channel.sv
// One colour channel of the blender: purely combinational src/dst/alpha/mode -> result.
// ALPHA_BLEND_ROUND_EN selects round-to-nearest instead of truncation in BLEND.
module alpha_blend_channel
    import alpha_blend_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
) (
    input  logic signed [DATA_W-1:0] src,
    input  logic signed [DATA_W-1:0] dst,
    input  logic signed [COEF_W-1:0] alpha,
    input  logic        [2:0]        mode,
    output logic signed [DATA_W-1:0] result
);

    localparam logic signed [ACC_W-1:0] ROUND_BIAS = 34'sd2048;

    logic signed [DATA_W:0]   add_w;
    logic signed [DATA_W:0]   sub_w;
    logic signed [COEF_W-1:0] inv;
    logic signed [ACC_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]  prod_d;
    logic signed [ACC_W-1:0]  acc;

    function automatic logic signed [ACC_W-1:0] widen(input logic signed [DATA_W:0] v);
        return ACC_W'(v);
    endfunction

    // Drop the 12 fractional bits of the alpha-weighted sum.
    function automatic logic signed [ACC_W-1:0] scale_q412(input logic signed [ACC_W-1:0] v);
`ifdef ALPHA_BLEND_ROUND_EN
        return (v + ROUND_BIAS) >>> 12;
`else
        return v >>> 12;
`endif
    endfunction

    assign add_w  = {src[DATA_W-1], src} + {dst[DATA_W-1], dst};
    assign sub_w  = {src[DATA_W-1], src} - {dst[DATA_W-1], dst};
    assign inv    = Q412_ONE - alpha;
    assign prod_s = ACC_W'(src) * ACC_W'(alpha);
    assign prod_d = ACC_W'(dst) * ACC_W'(inv);
    assign acc    = prod_s + prod_d;

    always_comb begin
        result = src;
        case (mode)
            BLEND_ADD:      result = q412_clamp(widen(add_w));
            BLEND_SUBTRACT: result = q412_clamp(widen(sub_w));
            BLEND_BLEND:    result = q412_clamp(scale_q412(acc));
            default:        result = src;
        endcase
    end

endmodule

// File: rtl/alpha_blend.sv
// RGBA-over-RGB blender, three identical channels with a single output register stage.
// Build option: ALPHA_BLEND_ROUND_EN enables rounding in BLEND mode (see alpha_blend_channel).
module alpha_blend
    import alpha_blend_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] src_rgba,
    input  logic [47:0] dst_rgb,
    input  logic [2:0]  blend_mode,
    output logic        out_valid,
    output logic [47:0] result_rgb
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;

    logic signed [COEF_W-1:0] alpha_raw;
    logic signed [COEF_W-1:0] alpha_c;
    logic        [47:0]       rgb_c;
    logic                     vld_p0;
    logic        [47:0]       rgb_p0;

    assign alpha_raw = src_rgba[15:0];
    assign alpha_c   = q412_clamp(ACC_W'(alpha_raw));

    // Channel 0 is B, 1 is G, 2 is R; src colour sits one lane above its dst lane.
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        alpha_blend_channel #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W)
        ) u_ch (
            .src    (src_rgba[16*(ch+1) +: 16]),
            .dst    (dst_rgb[16*ch +: 16]),
            .alpha  (alpha_c),
            .mode   (blend_mode),
            .result (rgb_c[16*ch +: 16])
        );
    end

    // ---- stage p0: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            rgb_p0 <= '0;
        end else begin
            vld_p0 <= in_valid;
            if (in_valid)
                rgb_p0 <= rgb_c;
        end
    end

    assign out_valid  = vld_p0;
    assign result_rgb = rgb_p0;

endmodule

// File: tb/tb_alpha_blend.sv
// Directed, table-driven bench for alpha_blend with reset and streaming sequences.
module tb_alpha_blend;

    typedef struct {
        string       name;
        logic [2:0]  mode;
        logic [63:0] src;
        logic [47:0] dst;
        logic [47:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] src_rgba;
    logic [47:0] dst_rgb;
    logic [2:0]  blend_mode;
    logic        out_valid;
    logic [47:0] result_rgb;

    int checks;
    int errors;
    vec_t vt[$];

    alpha_blend dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .src_rgba   (src_rgba),
        .dst_rgb    (dst_rgb),
        .blend_mode (blend_mode),
        .out_valid  (out_valid),
        .result_rgb (result_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_rgb(input string name, input logic [47:0] act, input logic [47:0] exp, input int tol);
        logic signed [15:0] a;
        logic signed [15:0] e;
        int d;
        bit bad;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a = act[16*c +: 16];
            e = exp[16*c +: 16];
            d = int'(a) - int'(e);
            if (d > tol || d < -tol || $isunknown(act[16*c +: 16])) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: got %h expected %h (tol %0d)", name, act, exp, tol);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] m, input logic [63:0] s,
                                input logic [47:0] d, input logic [47:0] e);
        vec_t v;
        v.name = n; v.mode = m; v.src = s; v.dst = d; v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid   = 1'b1;
        blend_mode = v.mode;
        src_rgba   = v.src;
        dst_rgb    = v.dst;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        src_rgba = '0;
        dst_rgb = '0;
        blend_mode = 3'b000;

        vt.push_back(mk("dis_basic",   3'b000, 64'h0800_0400_0C00_0000, 48'h1000_1000_1000, 48'h0800_0400_0C00));
        vt.push_back(mk("add_sat",     3'b001, 64'h0C00_0400_0000_0000, 48'h0800_0400_0000, 48'h1000_0800_0000));
        vt.push_back(mk("sub_basic",   3'b010, 64'h0C00_0400_0800_0000, 48'h0400_0C00_0800, 48'h0800_0000_0000));
        vt.push_back(mk("sub_full",    3'b010, 64'h1000_0000_0C00_0000, 48'h0000_0000_0400, 48'h1000_0000_0800));
        vt.push_back(mk("bld_a_one",   3'b011, 64'h1000_0000_0800_1000, 48'h0400_0C00_1000, 48'h1000_0000_0800));
        vt.push_back(mk("bld_a_zero",  3'b011, 64'h0800_0800_0800_0000, 48'h0000_1000_0400, 48'h0000_1000_0400));
        vt.push_back(mk("bld_a_qtr",   3'b011, 64'h0800_0800_1000_0400, 48'h1000_1000_0000, 48'h0E00_0E00_0400));
        vt.push_back(mk("bld_a_3qtr",  3'b011, 64'h1000_0000_0800_0C00, 48'h0000_0000_0800, 48'h0C00_0000_0800));
        vt.push_back(mk("rsv_100",     3'b100, 64'h0800_0400_0C00_0000, 48'h1000_1000_1000, 48'h0800_0400_0C00));
        vt.push_back(mk("rsv_111",     3'b111, 64'h0800_0400_0C00_0000, 48'h1000_1000_1000, 48'h0800_0400_0C00));
        vt.push_back(mk("dis_noclamp", 3'b000, 64'hF000_7FFF_1800_0000, 48'h0000_0000_0000, 48'hF000_7FFF_1800));
        vt.push_back(mk("add_17bit",   3'b001, 64'hF000_7000_0000_0000, 48'h0800_7000_FFFF, 48'h0000_1000_0000));
        vt.push_back(mk("bld_a_over",  3'b011, 64'h0800_0400_0C00_2000, 48'h0000_0000_0000, 48'h0800_0400_0C00));
        vt.push_back(mk("bld_a_neg",   3'b011, 64'h0800_0400_0C00_F000, 48'h0100_0200_0300, 48'h0100_0200_0300));
        vt.push_back(mk("bld_clamp",   3'b011, 64'hF000_1800_0800_1000, 48'h0000_0000_0000, 48'h0000_1000_0800));

        // Reset is combinational on the outputs
        #1;
        check_bit("rst_vld", out_valid, 1'b0);
        check_rgb("rst_rgb", result_rgb, 48'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Whole table streamed back-to-back, checked 1 cycle after each sample
        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i]);
            @(posedge clk);
            #1;
            check_bit({vt[i].name, "_vld"}, out_valid, 1'b1);
            check_rgb(vt[i].name, result_rgb, vt[i].exp, (vt[i].mode == 3'b011) ? 1 : 0);
        end

        // Idle cycle: valid drops, data holds even though inputs change
        @(negedge clk);
        in_valid = 1'b0;
        drive(vt[1]);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_bit("idle_vld", out_valid, 1'b0);
        check_rgb("idle_hold", result_rgb, vt[vt.size()-1].exp, 1);

        // Mid-stream reset with an operation in flight
        @(negedge clk);
        drive(vt[0]);
        @(posedge clk);
        #1;
        check_bit("pre_rst_vld", out_valid, 1'b1);
        @(negedge clk);
        drive(vt[2]);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("async_rst_vld", out_valid, 1'b0);
        check_rgb("async_rst_rgb", result_rgb, 48'h0, 0);
        @(posedge clk);
        #1;
        check_bit("rst_hold_vld", out_valid, 1'b0);
        check_rgb("rst_hold_rgb", result_rgb, 48'h0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_bit("post_rst_idle_vld", out_valid, 1'b0);

        // Four back-to-back samples after reset release
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(vt[k + 4]);
            @(posedge clk);
            #1;
            check_bit($sformatf("stream%0d_vld", k), out_valid, 1'b1);
            check_rgb($sformatf("stream%0d", k), result_rgb, vt[k + 4].exp, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_bit("stream_end_vld", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alpha_blend.md
ALPHA_BLEND -- requirements
Module: alpha_blend

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  qualifies src_rgba/dst_rgb/blend_mode this cycle.
REQ-004 src_rgba  input  64  source colour {R[63:48], G[47:32], B[31:16], A[15:0]}, each signed Q4.12 (0x1000 = 1.0).
REQ-005 dst_rgb  input  48  destination colour {R[47:32], G[31:16], B[15:0]}, signed Q4.12.
REQ-006 blend_mode  input  3  000 DISABLED, 001 ADD, 010 SUBTRACT, 011 BLEND, 100-111 reserved.
REQ-007 out_valid  output  1  result_rgb valid this cycle.
REQ-008 result_rgb  output  48  blended colour {R, G, B}, Q4.12, same packing as dst_rgb.

Function
REQ-009 Latency SHALL be exactly 1 cycle: inputs sampled with in_valid=1 at edge N appear on result_rgb with out_valid=1 after edge N; no backpressure, one result accepted every cycle.
REQ-010 out_valid SHALL equal in_valid delayed one cycle; result_rgb SHALL hold its last value when in_valid=0.
REQ-011 R, G and B SHALL be processed independently and identically; alpha is used only in BLEND.
REQ-012 DISABLED: channel = src channel, unmodified, no clamping.
REQ-013 ADD: channel = src + dst in 17-bit signed, clamped to [0x0000, 0x1000].
REQ-014 SUBTRACT: channel = src - dst in 17-bit signed, clamped to [0x0000, 0x1000]; negative results give 0x0000.
REQ-015 BLEND: a = src A clamped to [0, 0x1000]; inv = 0x1000 - a; channel = (src*a + dst*inv) >> 12 using full-width (>= 34-bit) signed products and sum, then clamped to [0x0000, 0x1000].
REQ-016 BLEND boundaries: a = 0x1000 yields src (clamped); a = 0 yields dst (clamped); each within +/-1 LSB.
REQ-017 Reserved modes 100-111 SHALL behave exactly as DISABLED.
REQ-018 Mode changes take effect on the next sampled input; there is no inter-cycle state other than the output registers.

Reset
REQ-019 While rst_n=0: out_valid = 0 and result_rgb = 0x000000000000, applied immediately without waiting for a clock edge.
REQ-020 After rst_n deasserts, the first result SHALL appear one cycle after the first in_valid=1 sample; an operation in flight when reset asserts SHALL be discarded.

Configuration
REQ-021 Macro ALPHA_BLEND_ROUND_EN: when defined, BLEND adds 0x800 to the sum before the >>12, i.e. round to nearest; when undefined, BLEND truncates. All other modes are unaffected.

Structure
REQ-022 Package alpha_blend_pkg SHALL hold the blend-mode enum (BLEND_DISABLED, BLEND_ADD, BLEND_SUBTRACT, BLEND_BLEND), Q412_ONE = 16'h1000, Q412_ZERO, and a Q4.12 clamp function.
REQ-023 Sub-module alpha_blend_channel (combinational, one colour channel: src, dst, alpha, mode -> result) SHALL be instantiated three times; alpha_blend owns the alpha clamp and the output registers.

Verification
REQ-024 DISABLED: src=(0x0800,0x0400,0x0C00,A=0), dst=all 0x1000 -> result (0x0800,0x0400,0x0C00) one cycle later, out_valid=1.
REQ-025 ADD: src 0x0C00 + dst 0x0800 -> 0x1000 (saturated); src 0x0400 + dst 0x0400 -> 0x0800; src 0 + dst 0 -> 0.
REQ-026 SUBTRACT: 0x0C00-0x0400 -> 0x0800; 0x0400-0x0C00 -> 0x0000; 0x0800-0x0800 -> 0x0000; 0x1000-0 -> 0x1000.
REQ-027 BLEND (+/-1 LSB): a=0x1000 src=(0x1000,0,0x0800) -> src; a=0 dst=(0,0x1000,0x0400) -> dst; a=0x0400 src=0x0800 dst=0x1000 -> 0x0E00; a=0x0C00 src=0x1000 dst=0 -> 0x0C00.
REQ-028 Modes 100 and 111 with src=(0x0800,0x0400,0x0C00) -> identical passthrough.
REQ-029 Reset and streaming: assert rst_n=0 mid-stream -> out_valid=0 and result 0 immediately; after release, back-to-back in_valid for 4 cycles -> 4 consecutive correct results at 1-cycle latency.
